// File: rtl/rotate_counterclockwise_kick_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rotate_counterclockwise_kick_pkg
// Description : Shared types for the counter-clockwise SRS rotation engine:
//               piece control word, kick offset type, CCW kick tables and
//               the engine state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package rotate_counterclockwise_kick_pkg;

    // Piece identifiers shared with the rest of the game logic
    localparam logic [2:0] TETROMINO_I_IDX = 3'd0;
    localparam logic [2:0] TETROMINO_O_IDX = 3'd1;
    localparam logic [2:0] TETROMINO_T_IDX = 3'd2;
    localparam logic [2:0] TETROMINO_S_IDX = 3'd3;
    localparam logic [2:0] TETROMINO_Z_IDX = 3'd4;
    localparam logic [2:0] TETROMINO_J_IDX = 3'd5;
    localparam logic [2:0] TETROMINO_L_IDX = 3'd6;

    localparam logic [2:0] LAST_K_FULL = 3'd4;
    localparam logic [2:0] LAST_K_O    = 3'd0;

    typedef struct packed {
        logic [3:0][3:0] data;
    } tetromino_t;

    // Board coordinate, y grows downwards; arithmetic wraps at field width
    typedef struct packed {
        logic [4:0] x;
        logic [4:0] y;
    } coord_t;

    typedef struct packed {
        logic [2:0] idx;
        tetromino_t tetromino;
        logic [1:0] rotation;
        coord_t     coordinate;
    } tetromino_ctrl;

    typedef struct packed {
        logic signed [2:0] dx;
        logic signed [2:0] dy;
    } kick_offset_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_NEXT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Indexed [source rotation][kick index]
    localparam kick_offset_t KICK_CCW_JLSTZ [4][5] = '{
        '{'{3'sd0, 3'sd0}, '{3'sd1, 3'sd0}, '{3'sd1, -3'sd1}, '{3'sd0, 3'sd2}, '{3'sd1, 3'sd2}},
        '{'{3'sd0, 3'sd0}, '{3'sd1, 3'sd0}, '{3'sd1, 3'sd1}, '{3'sd0, -3'sd2}, '{3'sd1, -3'sd2}},
        '{'{3'sd0, 3'sd0}, '{-3'sd1, 3'sd0}, '{-3'sd1, -3'sd1}, '{3'sd0, 3'sd2}, '{-3'sd1, 3'sd2}},
        '{'{3'sd0, 3'sd0}, '{-3'sd1, 3'sd0}, '{-3'sd1, 3'sd1}, '{3'sd0, -3'sd2}, '{-3'sd1, -3'sd2}}
    };

    localparam kick_offset_t KICK_CCW_I [4][5] = '{
        '{'{3'sd0, 3'sd0}, '{-3'sd1, 3'sd0}, '{3'sd2, 3'sd0}, '{-3'sd1, -3'sd2}, '{3'sd2, 3'sd1}},
        '{'{3'sd0, 3'sd0}, '{3'sd2, 3'sd0}, '{-3'sd1, 3'sd0}, '{3'sd2, -3'sd1}, '{-3'sd1, 3'sd2}},
        '{'{3'sd0, 3'sd0}, '{3'sd1, 3'sd0}, '{-3'sd2, 3'sd0}, '{3'sd1, 3'sd2}, '{-3'sd2, -3'sd1}},
        '{'{3'sd0, 3'sd0}, '{-3'sd2, 3'sd0}, '{3'sd1, 3'sd0}, '{-3'sd2, 3'sd1}, '{3'sd1, -3'sd2}}
    };

endpackage
`default_nettype wire

// File: rtl/srs_kick_table_ccw.sv
`default_nettype none
// ============================================================================
// Module      : srs_kick_table_ccw
// Description : Combinational SRS kick lookup for counter-clockwise rotation.
//               (piece idx, source rotation, kick index) -> (dx, dy, last k)
// Ports       : idx_i    - piece identifier
//               rot_i    - source rotation
//               k_i      - kick index (0..4)
//               dx_o     - signed x offset
//               dy_o     - signed y offset
//               last_k_o - highest kick index to try for this piece
// Revision    : 1.0 - initial release
// ============================================================================
module srs_kick_table_ccw
    import rotate_counterclockwise_kick_pkg::*;
(
    input  logic [2:0]        idx_i,
    input  logic [1:0]        rot_i,
    input  logic [2:0]        k_i,
    output logic signed [2:0] dx_o,
    output logic signed [2:0] dy_o,
    output logic [2:0]        last_k_o
);

    kick_offset_t w_kick;

    always_comb begin
        w_kick   = '0;
        last_k_o = LAST_K_FULL;
        if (idx_i == TETROMINO_O_IDX) begin
            // O is rotation-invariant in place: only the null kick exists
            last_k_o = LAST_K_O;
        end else if (k_i <= LAST_K_FULL) begin
            if (idx_i == TETROMINO_I_IDX) begin
                w_kick = KICK_CCW_I[rot_i][k_i];
            end else begin
                w_kick = KICK_CCW_JLSTZ[rot_i][k_i];
            end
        end
    end

    assign dx_o = w_kick.dx;
    assign dy_o = w_kick.dy;

endmodule
`default_nettype wire

// File: rtl/rotate_counterclockwise_kick.sv
`default_nettype none
// ============================================================================
// Module      : rotate_counterclockwise_kick
// Description : Sequential CCW rotation engine with SRS wall kicks. Tries up
//               to five kick candidates through a req/ack collision checker
//               and returns the first legal placement or the original piece.
// Ports       : clk_i, rst_ni          - clock, async active-low reset
//               start_i, t_in_i        - rotation request and piece
//               busy_o                 - engine occupied
//               chk_req_o, chk_cand_o  - candidate offered to checker
//               chk_ack_i, chk_collide_i - checker response
//               done_o, success_o, t_out_o - result
// Revision    : 1.0 - initial release
// ============================================================================
module rotate_counterclockwise_kick
    import rotate_counterclockwise_kick_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  tetromino_ctrl t_in_i,
    output logic          busy_o,
    output logic          chk_req_o,
    output tetromino_ctrl chk_cand_o,
    input  logic          chk_ack_i,
    input  logic          chk_collide_i,
    output logic          done_o,
    output logic          success_o,
    output tetromino_ctrl t_out_o
);

    state_e        state_q, state_d;
    tetromino_ctrl piece_q, piece_d;
    logic [2:0]    k_q, k_d;
    tetromino_ctrl t_out_q, t_out_d;
    logic          success_q, success_d;

    logic signed [2:0] w_dx;
    logic signed [2:0] w_dy;
    logic [2:0]        w_last_k;
    tetromino_ctrl     w_cand;

    srs_kick_table_ccw u_kick_table (
        .idx_i    (piece_q.idx),
        .rot_i    (piece_q.rotation),
        .k_i      (k_q),
        .dx_o     (w_dx),
        .dy_o     (w_dy),
        .last_k_o (w_last_k)
    );

    // Candidate: rotation minus one (wraps 0 -> 3), coordinate plus kick,
    // sign-extended offsets added with natural truncation
    always_comb begin
        w_cand              = piece_q;
        w_cand.rotation     = piece_q.rotation - 2'd1;
        w_cand.coordinate.x = piece_q.coordinate.x + {{2{w_dx[2]}}, w_dx};
        w_cand.coordinate.y = piece_q.coordinate.y + {{2{w_dy[2]}}, w_dy};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            piece_q   <= '0;
            k_q       <= '0;
            t_out_q   <= '0;
            success_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            piece_q   <= piece_d;
            k_q       <= k_d;
            t_out_q   <= t_out_d;
            success_q <= success_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        piece_d   = piece_q;
        k_d       = k_q;
        t_out_d   = t_out_q;
        success_d = success_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    piece_d = t_in_i;
                    k_d     = 3'd0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (chk_ack_i) begin
                    if (!chk_collide_i) begin
                        t_out_d   = w_cand;
                        success_d = 1'b1;
                        state_d   = ST_DONE;
                    end else if (k_q == w_last_k) begin
                        t_out_d   = piece_q;
                        success_d = 1'b0;
                        state_d   = ST_DONE;
                    end else begin
                        k_d     = k_q + 3'd1;
                        state_d = ST_NEXT;
                    end
                end
            end
            ST_NEXT: state_d = ST_REQ;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_o     = (state_q != ST_IDLE);
    assign chk_req_o  = (state_q == ST_REQ);
    // Candidate bus is zeroed outside REQ so the reset value is all zeros
    assign chk_cand_o = (state_q == ST_REQ) ? w_cand : '0;
    assign done_o     = (state_q == ST_DONE);
    assign success_o  = success_q;
    assign t_out_o    = t_out_q;

endmodule
`default_nettype wire

// File: tb/tb_rotate_counterclockwise_kick.sv
`default_nettype none
// ============================================================================
// Module      : tb_rotate_counterclockwise_kick
// Description : Self-checking bench for rotate_counterclockwise_kick with a
//               behavioural kick/latency model and randomized transactions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rotate_counterclockwise_kick;
    import rotate_counterclockwise_kick_pkg::*;

    logic          clk_i;
    logic          rst_ni;
    logic          start_i;
    tetromino_ctrl t_in_i;
    logic          busy_o;
    logic          chk_req_o;
    tetromino_ctrl chk_cand_o;
    logic          chk_ack_i;
    logic          chk_collide_i;
    logic          done_o;
    logic          success_o;
    tetromino_ctrl t_out_o;

    int n_checks = 0;
    int n_fail   = 0;

    rotate_counterclockwise_kick dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .t_in_i        (t_in_i),
        .busy_o        (busy_o),
        .chk_req_o     (chk_req_o),
        .chk_cand_o    (chk_cand_o),
        .chk_ack_i     (chk_ack_i),
        .chk_collide_i (chk_collide_i),
        .done_o        (done_o),
        .success_o     (success_o),
        .t_out_o       (t_out_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Kick offsets written out as (dx, dy) integer pairs, [rotation][k]
    int JL_DX [4][5] = '{'{0, 1, 1, 0, 1}, '{0, 1, 1, 0, 1}, '{0, -1, -1, 0, -1}, '{0, -1, -1, 0, -1}};
    int JL_DY [4][5] = '{'{0, 0, -1, 2, 2}, '{0, 0, 1, -2, -2}, '{0, 0, -1, 2, 2}, '{0, 0, 1, -2, -2}};
    int I_DX  [4][5] = '{'{0, -1, 2, -1, 2}, '{0, 2, -1, 2, -1}, '{0, 1, -2, 1, -2}, '{0, -2, 1, -2, 1}};
    int I_DY  [4][5] = '{'{0, 0, 0, -2, 1}, '{0, 0, 0, -1, 2}, '{0, 0, 0, 2, -1}, '{0, 0, 0, 1, -2}};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic tetromino_ctrl mk(input int idx, input int r, input int x, input int y);
        tetromino_ctrl t;
        t.idx            = 3'(idx);
        t.tetromino.data = 16'($urandom);
        t.rotation       = 2'(r);
        t.coordinate.x   = 5'(x);
        t.coordinate.y   = 5'(y);
        return t;
    endfunction

    function automatic int model_last(input tetromino_ctrl t);
        return (t.idx == TETROMINO_O_IDX) ? 0 : 4;
    endfunction

    function automatic tetromino_ctrl model_cand(input tetromino_ctrl t, input int k);
        tetromino_ctrl c;
        int dx, dy, r;
        r = int'(t.rotation);
        if (t.idx == TETROMINO_O_IDX) begin
            dx = 0; dy = 0;
        end else if (t.idx == TETROMINO_I_IDX) begin
            dx = I_DX[r][k]; dy = I_DY[r][k];
        end else begin
            dx = JL_DX[r][k]; dy = JL_DY[r][k];
        end
        c              = t;
        c.rotation     = 2'((r + 3) % 4);
        c.coordinate.x = 5'((int'(t.coordinate.x) + dx) & 31);
        c.coordinate.y = 5'((int'(t.coordinate.y) + dy) & 31);
        return c;
    endfunction

    // One full rotation: drives start, acts as the checker (mask bit k = collide
    // on attempt k, random stall up to stall_max cycles per request)
    task automatic run_rot(input tetromino_ctrl t, input logic [4:0] mask, input int stall_max,
                           input bit poke_start, output tetromino_ctrl r_out, output int r_cyc,
                           output int r_req, output bit r_succ);
        int cyc, nreq, stall_left, total_stall, last, exp_req, exp_cyc, ki;
        bit got_done, exp_succ;
        tetromino_ctrl exp_out;

        last     = model_last(t);
        exp_req  = last + 1;
        exp_succ = 1'b0;
        exp_out  = t;
        for (int i = 0; i <= last; i++) begin
            if (!mask[i]) begin
                exp_req  = i + 1;
                exp_succ = 1'b1;
                exp_out  = model_cand(t, i);
                break;
            end
        end

        @(negedge clk_i);
        start_i = 1'b1;
        t_in_i  = t;
        @(negedge clk_i);
        start_i = 1'b0;
        t_in_i  = mk($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 31));
        cyc         = 1;
        nreq        = 0;
        stall_left  = -1;
        total_stall = 0;
        got_done    = 1'b0;
        r_out       = '0;
        r_succ      = 1'b0;
        while (cyc < 200 && !got_done) begin
            chk_ack_i     = 1'b0;
            chk_collide_i = 1'b0;
            if (done_o) begin
                got_done = 1'b1;
                r_out    = t_out_o;
                r_succ   = success_o;
            end else if (chk_req_o) begin
                if (stall_left < 0) begin
                    stall_left   = $urandom_range(0, stall_max);
                    total_stall += stall_left;
                    nreq++;
                end
                ki = (nreq > 5) ? 4 : nreq - 1;
                check_eq("cand", 64'(chk_cand_o), 64'(model_cand(t, ki)));
                check_eq("busy_in_req", 64'(busy_o), 64'(1));
                if (stall_left == 0) begin
                    chk_ack_i     = 1'b1;
                    chk_collide_i = mask[ki];
                    stall_left    = -1;
                end else begin
                    stall_left--;
                end
            end
            if (poke_start && cyc == 2 && !got_done) begin
                start_i = 1'b1;
                t_in_i  = mk(TETROMINO_I_IDX, 1, 20, 20);
            end else begin
                start_i = 1'b0;
            end
            if (!got_done) begin
                @(negedge clk_i);
                cyc++;
            end
        end
        start_i       = 1'b0;
        chk_ack_i     = 1'b0;
        chk_collide_i = 1'b0;
        r_cyc = cyc;
        r_req = nreq;
        check_eq("done_seen", 64'(got_done), 64'(1));
        exp_cyc = 2 + 2 * (exp_req - 1) + total_stall;
        check_eq("done_cycle", 64'(cyc), 64'(exp_cyc));
        check_eq("req_count", 64'(nreq), 64'(exp_req));
        check_eq("success", 64'(r_succ), 64'(exp_succ));
        check_eq("t_out", 64'(r_out), 64'(exp_out));
        // Result must persist after the done pulse
        @(negedge clk_i);
        check_eq("done_pulse", 64'(done_o), 64'(0));
        check_eq("busy_after", 64'(busy_o), 64'(0));
        check_eq("t_out_held", 64'(t_out_o), 64'(exp_out));
        check_eq("success_held", 64'(success_o), 64'(exp_succ));
    endtask

    initial begin
        tetromino_ctrl t, r_out;
        int r_cyc, r_req;
        bit r_succ;

        rst_ni        = 1'b0;
        start_i       = 1'b0;
        t_in_i        = '0;
        chk_ack_i     = 1'b0;
        chk_collide_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check_eq("rst_busy", 64'(busy_o), 64'(0));
        check_eq("rst_req", 64'(chk_req_o), 64'(0));
        check_eq("rst_done", 64'(done_o), 64'(0));
        check_eq("rst_success", 64'(success_o), 64'(0));
        check_eq("rst_t_out", 64'(t_out_o), 64'(0));
        check_eq("rst_cand", 64'(chk_cand_o), 64'(0));
        rst_ni = 1'b1;

        // 1: T at (5,5), r=0, no collision
        t = mk(TETROMINO_T_IDX, 0, 5, 5);
        run_rot(t, 5'b00000, 0, 1'b0, r_out, r_cyc, r_req, r_succ);
        check_eq("s1_cyc", 64'(r_cyc), 64'(2));
        check_eq("s1_rot", 64'(r_out.rotation), 64'(3));
        check_eq("s1_xy", 64'({r_out.coordinate.x, r_out.coordinate.y}), 64'({5'd5, 5'd5}));

        // 2: T r=0, collide k=0,1, clear k=2
        t = mk(TETROMINO_T_IDX, 0, 5, 5);
        run_rot(t, 5'b11011, 0, 1'b0, r_out, r_cyc, r_req, r_succ);
        check_eq("s2_cyc", 64'(r_cyc), 64'(6));
        check_eq("s2_xy", 64'({r_out.coordinate.x, r_out.coordinate.y}), 64'({5'd6, 5'd4}));

        // 3: I at (5,5), r=2, all collide
        t = mk(TETROMINO_I_IDX, 2, 5, 5);
        run_rot(t, 5'b11111, 0, 1'b0, r_out, r_cyc, r_req, r_succ);
        check_eq("s3_cyc", 64'(r_cyc), 64'(10));
        check_eq("s3_out", 64'(r_out), 64'(t));
        check_eq("s3_last_cand", 64'({model_cand(t, 4).coordinate.x, model_cand(t, 4).coordinate.y}),
                 64'({5'd3, 5'd4}));

        // 4: O collide, then O wrap
        t = mk(TETROMINO_O_IDX, 0, 4, 4);
        run_rot(t, 5'b11111, 0, 1'b0, r_out, r_cyc, r_req, r_succ);
        check_eq("s4_req", 64'(r_req), 64'(1));
        check_eq("s4_cyc", 64'(r_cyc), 64'(2));
        t = mk(TETROMINO_O_IDX, 0, 4, 4);
        run_rot(t, 5'b00000, 0, 1'b0, r_out, r_cyc, r_req, r_succ);
        check_eq("s4_wrap", 64'(r_out.rotation), 64'(3));

        // 5: checker stalls 3 cycles, start poked while busy
        t = mk(TETROMINO_J_IDX, 1, 0, 0);
        run_rot(t, 5'b00011, 3, 1'b1, r_out, r_cyc, r_req, r_succ);

        // 6: reset while in REQ
        @(negedge clk_i);
        start_i = 1'b1;
        t_in_i  = mk(TETROMINO_T_IDX, 0, 5, 5);
        @(negedge clk_i);
        start_i = 1'b0;
        check_eq("s6_req_before", 64'(chk_req_o), 64'(1));
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        check_eq("s6_req_async", 64'(chk_req_o), 64'(0));
        check_eq("s6_busy_async", 64'(busy_o), 64'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check_eq("s6_no_done", 64'(done_o), 64'(0));
        end
        t = mk(TETROMINO_T_IDX, 0, 5, 5);
        run_rot(t, 5'b00000, 0, 1'b0, r_out, r_cyc, r_req, r_succ);
        check_eq("s6_cyc", 64'(r_cyc), 64'(2));

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            t = mk($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 31));
            run_rot(t, ($urandom_range(0, 3) == 0) ? 5'b11111 : 5'($urandom), 2, 1'($urandom),
                    r_out, r_cyc, r_req, r_succ);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rotate_counterclockwise_kick.md
# rotate_counterclockwise_kick

Sequential counter-clockwise rotation engine with SRS wall kicks, the reverse-direction counterpart of the combinational clockwise rotator. On a `start` pulse it takes the active piece (`tetromino_ctrl`), generates rotation-minus-one candidates at up to five kick offsets, and tests each one in turn through a request/acknowledge handshake with the board collision checker. It returns the first legal placement, or the unchanged piece if every offset collides. It sits between the input/game FSM and the collision checker.

## Interface
- No parameters; kick tables come from the shared package.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `t_in` in `tetromino_ctrl`: piece to rotate; latched on accepted `start`.
- `busy` out 1: high from the cycle after accepted `start` until DONE exits.
- `chk_req` out 1: candidate valid; held until acknowledged.
- `chk_cand` out `tetromino_ctrl`: candidate placement; stable while `chk_req` is high.
- `chk_ack` in 1: one-cycle checker response.
- `chk_collide` in 1: valid with `chk_ack`; 1 = candidate illegal.
- `done` out 1: one-cycle completion pulse.
- `success` out 1: valid with `done` and held until the next `done`; 1 = rotated.
- `t_out` out `tetromino_ctrl`: result; valid with `done` and held until the next `done`.

## Operation
- **Candidate fields:**
  - `idx` and `tetromino.data[0..3]` are copied from the latched piece.
  - `rotation` = (r − 1) mod 4, so 0 wraps to 3.
  - `coordinate` = latched coordinate + kick[k].
  - Addition is two's complement at the field width, truncated; bounds are the checker's job.
- **Kick offsets** (dx, dy in board frame, y down), k = 0..4, indexed by source rotation r:
  - JLSTZ, r=0: (0,0) (+1,0) (+1,−1) (0,+2) (+1,+2)
  - JLSTZ, r=1: (0,0) (+1,0) (+1,+1) (0,−2) (+1,−2)
  - JLSTZ, r=2: (0,0) (−1,0) (−1,−1) (0,+2) (−1,+2)
  - JLSTZ, r=3: (0,0) (−1,0) (−1,+1) (0,−2) (−1,−2)
  - I, r=0: (0,0) (−1,0) (+2,0) (−1,−2) (+2,+1)
  - I, r=1: (0,0) (+2,0) (−1,0) (+2,−1) (−1,+2)
  - I, r=2: (0,0) (+1,0) (−2,0) (+1,+2) (−2,−1)
  - I, r=3: (0,0) (−2,0) (+1,0) (−2,+1) (+1,−2)
  - O: only k=0, (0,0), is tried; last index = 0. For all other pieces, last index = 4.
- **FSM states:** IDLE, REQ, NEXT, DONE.
  - IDLE: on `start`, latch `t_in`, set k=0, go to REQ.
  - REQ: `chk_req`=1. When `chk_ack`:
    - `!chk_collide`: `t_out`=candidate, `success`=1, go to DONE.
    - `chk_collide` and k=last: `t_out`=latched piece, `success`=0, go to DONE.
    - otherwise: k++, go to NEXT.
  - NEXT: `chk_req`=0 for one cycle, then go to REQ.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- `start` is ignored outside IDLE (no queueing).
- `chk_ack` is ignored outside REQ.

## Timing
- **Reset values:** state IDLE; `busy`, `chk_req`, `done`, `success` = 0; `t_out`, `chk_cand` = all zeros.
- Asserting `rst_n` low mid-operation drops `chk_req` immediately and discards the attempt; no `done` is produced.
- **Latency** (start sampled at edge 0, checker acknowledging in the first REQ cycle):
  - Success at k=0: `chk_req` high in cycle 1, `done` in cycle 2.
  - Each additional kick adds 2 cycles (NEXT + REQ).
  - Worst case, all five collide: `done` in cycle 10.
- Checker wait states extend REQ without limit; there is no timeout.
- `chk_ack` arriving in the same cycle `chk_req` first rises is legal and accepted.
- `t_out` and `success` update on the edge that enters DONE, so they are valid in the same cycle as `done`.

## Structure
- Shared package: `kick_offset_t` (signed dx, dy, 3 bits each), the `KICK_CCW_JLSTZ` and `KICK_CCW_I` tables ([4][5]), and a state enum.
- Existing `TETROMINO_*_IDX` defines are reused.
- Sub-module `srs_kick_table_ccw`: combinational lookup (idx, r, k) → (dx, dy, last_k). A future clockwise kick engine reuses the same structure.

## Test plan
1. T at (5,5), r=0, checker never collides: `done` in cycle 2, `t_out`.rotation=3, coordinate (5,5), `success`=1, exactly one request.
2. T, r=0, collide on k=0 and k=1, clear on k=2: `t_out` coordinate (6,4), rotation 3, three requests with one NEXT gap between each, `done` in cycle 6.
3. I at (5,5), r=2, all five collide: `success`=0, `t_out` equals `t_in` (r=2, (5,5)), `done` in cycle 10; candidates requested at (5,5), (6,5), (3,5), (6,7), (3,4).
4. O, r=0, collide: exactly one request, `success`=0, `done` in cycle 2. Rotation wrap: O, r=0, no collision → rotation 3.
5. Checker stalls 3 cycles before `chk_ack`: `chk_req` and `chk_cand` held stable throughout. A `start` pulsed while `busy` is ignored.
6. `rst_n` asserted while in REQ: `chk_req`, `busy` → 0 asynchronously. After release, a new `start` completes normally per scenario 1.
